// File: rtl/hidden_backprop_seq_pkg.sv
// hbp_pkg: shared types and helpers for the hidden-neuron weight-update engine.
//   - hbp_state_e : FSM state encoding
//   - *_DEF       : default parameter values for the engine and its interface
//   - err_w/prod_w/sum_w : derived datapath widths
//   - sat_to_w    : clamp a wide signed value into a W-bit two's-complement range
package hbp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } hbp_state_e;

  localparam int unsigned N_IN_DEF     = 4;
  localparam int unsigned W_WIDTH_DEF  = 8;
  localparam int unsigned H_WIDTH_DEF  = 10;
  localparam int unsigned F_WIDTH_DEF  = 19;
  localparam int unsigned LR_SHIFT_DEF = 12;

  // Working width of the clamp helper; every datapath width must fit in it.
  localparam int unsigned SAT_CALC_W = 64;

  // target - final needs one extra bit to never overflow.
  function automatic int unsigned err_w(input int unsigned f_width);
    return f_width + 1;
  endfunction

  // (err * 2) is err_w+1 bits; hidden is zero-extended to h_width+1 signed bits.
  function automatic int unsigned prod_w(input int unsigned f_width,
                                         input int unsigned h_width);
    return err_w(f_width) + 1 + h_width + 1;
  endfunction

  function automatic int unsigned sum_w(input int unsigned d_width,
                                        input int unsigned w_width);
    return ((d_width > w_width) ? d_width : w_width) + 1;
  endfunction

  localparam int unsigned ERR_W_DEF  = err_w(F_WIDTH_DEF);
  localparam int unsigned PROD_W_DEF = prod_w(F_WIDTH_DEF, H_WIDTH_DEF);
  localparam int unsigned SUM_W_DEF  = sum_w(PROD_W_DEF, W_WIDTH_DEF);

  function automatic logic signed [SAT_CALC_W-1:0] sat_to_w(
    input logic signed [SAT_CALC_W-1:0] value,
    input int unsigned                  w_width
  );
    logic signed [SAT_CALC_W-1:0] hi;
    logic signed [SAT_CALC_W-1:0] lo;
    hi = (64'sd1 <<< (w_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w_width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/hidden_backprop_seq_if.sv
// hidden_backprop_seq_if: control/data bundle between the training controller
// (master) and the weight-update engine (slave).
//   slave inputs : en_i, start_i, x_i, hidden_val_i, final_i, target_i,
//                  zero_weight_reset_i, load_i, load_idx_i, load_data_i
//   slave outputs: w_flat_o (weight 0 in LSBs), busy_o, done_o, sat_o
interface hidden_backprop_seq_if
  import hbp_pkg::*;
#(
  parameter int unsigned N_IN    = N_IN_DEF,
  parameter int unsigned W_WIDTH = W_WIDTH_DEF,
  parameter int unsigned H_WIDTH = H_WIDTH_DEF,
  parameter int unsigned F_WIDTH = F_WIDTH_DEF
);

  localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic                      en_i;
  logic                      start_i;
  logic [N_IN-1:0]           x_i;
  logic [H_WIDTH-1:0]        hidden_val_i;
  logic [F_WIDTH-1:0]        final_i;
  logic [F_WIDTH-1:0]        target_i;
  logic                      zero_weight_reset_i;
  logic                      load_i;
  logic [IDX_W-1:0]          load_idx_i;
  logic [W_WIDTH-1:0]        load_data_i;
  logic [N_IN*W_WIDTH-1:0]   w_flat_o;
  logic                      busy_o;
  logic                      done_o;
  logic                      sat_o;

  modport slave (
    input  en_i, start_i, x_i, hidden_val_i, final_i, target_i,
           zero_weight_reset_i, load_i, load_idx_i, load_data_i,
    output w_flat_o, busy_o, done_o, sat_o
  );

  modport master (
    output en_i, start_i, x_i, hidden_val_i, final_i, target_i,
           zero_weight_reset_i, load_i, load_idx_i, load_data_i,
    input  w_flat_o, busy_o, done_o, sat_o
  );

endinterface

// File: rtl/hidden_backprop_seq_sat_step.sv
// hbp_sat_step: combinational single-weight update.
//   w_i     : current weight (signed, W_WIDTH)
//   delta_i : scaled gradient step (signed, D_WIDTH)
//   w_o     : w_i + delta_i clamped to the W_WIDTH signed range
//   sat_o   : high when the clamp changed the sum
module hbp_sat_step
  import hbp_pkg::*;
#(
  parameter int unsigned W_WIDTH = W_WIDTH_DEF,
  parameter int unsigned D_WIDTH = PROD_W_DEF
) (
  input  logic signed [W_WIDTH-1:0] w_i,
  input  logic signed [D_WIDTH-1:0] delta_i,
  output logic signed [W_WIDTH-1:0] w_o,
  output logic                      sat_o
);

  localparam int unsigned SUM_W = sum_w(D_WIDTH, W_WIDTH);

  logic signed [SUM_W-1:0]      sum;
  logic signed [SAT_CALC_W-1:0] sum_ext;
  logic signed [SAT_CALC_W-1:0] clamped;

  always_comb begin
    sum     = SUM_W'(w_i) + SUM_W'(delta_i);
    sum_ext = SAT_CALC_W'(sum);
    clamped = sat_to_w(sum_ext, W_WIDTH);
    w_o     = clamped[W_WIDTH-1:0];
    sat_o   = (clamped != sum_ext);
  end

endmodule

// File: rtl/hidden_backprop_seq.sv
// hidden_backprop_seq: sequential weight-update engine for one hidden neuron.
// On start it latches the forward result, target, hidden activation and input
// mask, then walks the weights one per cycle applying a saturating,
// learning-rate-scaled gradient step to weights whose input bit is set.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : hidden_backprop_seq_if.slave (controls, operands, weights, status)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; direct weight loads accepted
// ST_UPDATE | processing weight idx_q, one per enabled cycle
// ST_DONE   | one-cycle done pulse, returns to ST_IDLE unconditionally
module hidden_backprop_seq
  import hbp_pkg::*;
#(
  parameter int unsigned N_IN     = N_IN_DEF,
  parameter int unsigned W_WIDTH  = W_WIDTH_DEF,
  parameter int unsigned H_WIDTH  = H_WIDTH_DEF,
  parameter int unsigned F_WIDTH  = F_WIDTH_DEF,
  parameter int unsigned LR_SHIFT = LR_SHIFT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hidden_backprop_seq_if.slave  bus
);

  localparam int unsigned IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned ERR_W  = err_w(F_WIDTH);
  localparam int unsigned GRAD_W = ERR_W + 1;
  localparam int unsigned PROD_W = prod_w(F_WIDTH, H_WIDTH);

  hbp_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [N_IN-1:0]           x_q;
  logic [H_WIDTH-1:0]        hid_q;
  logic signed [F_WIDTH-1:0] fin_q;
  logic signed [F_WIDTH-1:0] tgt_q;
  logic signed [W_WIDTH-1:0] w_q [N_IN];
  logic                      sat_q;

  logic capture;
  logic step;
  logic load_we;
  logic last_idx;

  logic signed [ERR_W-1:0]   err;
  logic signed [GRAD_W-1:0]  grad;
  logic signed [H_WIDTH:0]   hid_ext;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  delta;
  logic signed [W_WIDTH-1:0] cur_w;
  logic signed [W_WIDTH-1:0] new_w;
  logic                      new_sat;
  logic [N_IN*W_WIDTH-1:0]   w_flat;

  assign last_idx = (idx_q == IDX_W'(N_IN - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i && bus.en_i) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
          capture = 1'b1;
        end
      end
      ST_UPDATE: begin
        if (bus.en_i) begin
          step = 1'b1;
          if (last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Clearing the weights aborts any pass in flight without a done pulse.
    if (bus.zero_weight_reset_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      capture = 1'b0;
      step    = 1'b0;
    end
  end

  assign load_we = (state_q == ST_IDLE) && bus.load_i && !bus.zero_weight_reset_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q   <= '0;
      hid_q <= '0;
      fin_q <= '0;
      tgt_q <= '0;
    end else if (capture) begin
      x_q   <= bus.x_i;
      hid_q <= bus.hidden_val_i;
      fin_q <= bus.final_i;
      tgt_q <= bus.target_i;
    end
  end

  // The step is identical for every weight in a pass; only the mask differs.
  always_comb begin
    err     = ERR_W'(tgt_q) - ERR_W'(fin_q);
    grad    = $signed({err, 1'b0});
    hid_ext = $signed({1'b0, hid_q});
    prod    = PROD_W'(grad) * PROD_W'(hid_ext);
    delta   = prod >>> LR_SHIFT;
    cur_w   = w_q[idx_q];
  end

  hbp_sat_step #(
    .W_WIDTH (W_WIDTH),
    .D_WIDTH (PROD_W)
  ) u_sat_step (
    .w_i     (cur_w),
    .delta_i (delta),
    .w_o     (new_w),
    .sat_o   (new_sat)
  );

  // A load in the same cycle as start lands before the first weight is read.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.zero_weight_reset_i) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        w_q[i] <= '0;
      end
    end else begin
      if (load_we) begin
        w_q[bus.load_idx_i] <= bus.load_data_i;
      end
      if (step && x_q[idx_q]) begin
        w_q[idx_q] <= new_w;
      end
    end
  end

  // Sticky across zero_weight_reset so the controller can still read it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_q <= 1'b0;
    end else if (capture) begin
      sat_q <= 1'b0;
    end else if (step && x_q[idx_q] && new_sat) begin
      sat_q <= 1'b1;
    end
  end

  always_comb begin
    w_flat = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      w_flat[i*W_WIDTH +: W_WIDTH] = w_q[i];
    end
  end

  assign bus.w_flat_o = w_flat;
  assign bus.busy_o   = (state_q != ST_IDLE);
  assign bus.done_o   = (state_q == ST_DONE);
  assign bus.sat_o    = sat_q;

endmodule
